// File: rtl/tx_chip_upsampler.sv
// Chip FIFO + zero-stuffing upsampler feeding the TX pulse-shaping FIR.
// Ports: chip_in/chip_valid/chip_ready in, x_out/nd_out/phase/underrun/fifo_level out.
module tx_chip_upsampler #(
  parameter int DW         = 16,
  parameter int OSR        = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PREFILL    = 2,
  localparam int PHW = (OSR > 1) ? $clog2(OSR) : 1,
  localparam int LW  = $clog2(FIFO_DEPTH) + 1,
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic           clk_30p72MHz,
  input  logic           reset,
  input  logic           en,
  input  logic [DW-1:0]  chip_in,
  input  logic           chip_valid,
  output logic           chip_ready,
  input  logic           rfd_in,
  output logic [DW-1:0]  x_out,
  output logic           nd_out,
  output logic [PHW-1:0] phase,
  output logic           underrun,
  output logic [LW-1:0]  fifo_level
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level_q;
  logic [PHW-1:0]  phase_q;
  logic            push;
  logic            pop;
  logic            emit;
  logic            starve;
  logic            sym_start;
  logic            sym_last;
  logic            is_empty;

  assign is_empty   = (level_q == '0);
  assign chip_ready = (level_q != LW'(FIFO_DEPTH));
  assign fifo_level = level_q;
  assign phase      = phase_q;

  assign push      = chip_valid & chip_ready;
  assign emit      = (state_q != IDLE) & rfd_in;
  assign sym_start = (phase_q == '0);
  assign sym_last  = (phase_q == PHW'(OSR - 1));
  // Chips are only consumed at the head of a symbol period in RUN.
  assign pop       = emit & (state_q == RUN) & sym_start & ~is_empty;
  assign starve    = emit & (state_q == RUN) & sym_start & is_empty;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en && (level_q >= LW'(PREFILL)))
          state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          // A stalled phase 0 means no period was started: nothing to drain.
          if ((rfd_in && sym_last) || (!rfd_in && sym_start))
            state_d = IDLE;
          else
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (en)
          state_d = RUN;
        else if (rfd_in && sym_last)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_30p72MHz) begin
    if (push)
      mem[wr_ptr] <= chip_in;
  end

  always_ff @(posedge clk_30p72MHz or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      phase_q  <= '0;
      x_out    <= '0;
      nd_out   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      nd_out   <= emit;
      underrun <= starve;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (emit) begin
        phase_q <= phase_q + 1'b1;
        x_out   <= pop ? mem[rd_ptr] : '0;
      end
    end
  end

endmodule
